// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port single-memory arbiter with valid/ready grants and tagged read returns
module mem_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_read_en,
  output logic                             mem_write_en,
  output logic [DATA_WIDTH-1:0]            mem_write_val,
  input  logic [DATA_WIDTH-1:0]            mem_read_val
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0]           ptr;
  logic [PW-1:0]           grant_id;
  logic                    grant_any;
  logic [PW:0]             cand;
  logic [READ_LATENCY-1:0] tag_v;
  logic [PW-1:0]           tag_id [READ_LATENCY];

  // Scan ports starting at ptr (round-robin) or at 0 (fixed priority); first requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    req_ready = '0;
    if (!rst) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (ARB_MODE == 1) begin
          cand = (PW+1)'(k);
        end else begin
          cand = {1'b0, ptr} + (PW+1)'(k);
          if (cand >= (PW+1)'(NUM_PORTS))
            cand = cand - (PW+1)'(NUM_PORTS);
        end
        if (!grant_any && req_valid[cand[PW-1:0]]) begin
          grant_any = 1'b1;
          grant_id  = cand[PW-1:0];
        end
      end
      if (grant_any)
        req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    mem_addr      = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_write_val = '0;
    if (grant_any) begin
      mem_addr      = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_write_en  = req_write[grant_id];
      mem_read_en   = ~req_write[grant_id];
      mem_write_val = req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (grant_any)
      ptr <= (grant_id == PW'(NUM_PORTS-1)) ? '0 : grant_id + 1'b1;
  end

  // Tag pipeline tracks which port owns the read data emerging from the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= mem_read_en;
      tag_id[0] <= grant_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_v[READ_LATENCY-1]) begin
        rsp_valid[tag_id[READ_LATENCY-1]] <= 1'b1;
        rsp_rdata[int'(tag_id[READ_LATENCY-1])*DATA_WIDTH +: DATA_WIDTH] <= mem_read_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench: round-robin (latency 3) and fixed-priority (latency 1) instances
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NP = 4;

  typedef struct packed {
    logic [7:0]    port;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    vld [2];
  logic [NP-1:0]    rdy [2];
  logic [NP-1:0]    wr  [2];
  logic [NP-1:0]    rsv [2];
  logic [NP*AW-1:0] adr [2];
  logic [NP*DW-1:0] wdt [2];
  logic [NP*DW-1:0] rdt [2];
  logic [AW-1:0]    maddr [2];
  logic             mre [2];
  logic             mwe [2];
  logic [DW-1:0]    mwv [2];
  logic [DW-1:0]    mrv [2];

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
    .req_addr(adr[0]), .req_wdata(wdt[0]), .rsp_valid(rsv[0]), .rsp_rdata(rdt[0]),
    .mem_addr(maddr[0]), .mem_read_en(mre[0]), .mem_write_en(mwe[0]),
    .mem_write_val(mwv[0]), .mem_read_val(mrv[0]));

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
    .req_addr(adr[1]), .req_wdata(wdt[1]), .rsp_valid(rsv[1]), .rsp_rdata(rdt[1]),
    .mem_addr(maddr[1]), .mem_read_en(mre[1]), .mem_write_en(mwe[1]),
    .mem_write_val(mwv[1]), .mem_read_val(mrv[1]));

  // Memory macros seen by the DUTs, and independent reference copies for the model.
  logic [DW-1:0] bmem [2][256];
  logic [DW-1:0] rmem [2][256];
  logic [DW-1:0] pipe [2][4];
  int            lat  [2] = '{3, 1};
  int            mode [2] = '{0, 1};

  assign mrv[0] = pipe[0][2];
  assign mrv[1] = pipe[1][0];

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            ptr [2] = '{0, 0};
  int            gnt [2] = '{-1, -1};
  logic [NP-1:0] granted [2];
  logic [DW-1:0] exp_rd [2][NP];
  rsp_t          expq [2][$];

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, inst, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= mre[i] ? bmem[i][maddr[i]] : 32'h0;
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
      if (mwe[i]) bmem[i][maddr[i]] <= mwv[i];
    end
  end

  // Model state advance: cycle count, arbitration pointer, reset flush.
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ptr[i] = 0;
        expq[i].delete();
        for (int p = 0; p < NP; p++) exp_rd[i][p] = '0;
      end else if (gnt[i] >= 0) begin
        ptr[i] = (gnt[i] + 1) % NP;
      end
    end
  end

  // Request-side checker: predicts the grant and memory drive, queues expected read returns.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int eg;
      logic [NP-1:0] er;
      logic [AW-1:0] ea;
      logic          ew;
      logic [DW-1:0] ed;
      rsp_t          e;
      eg = -1;
      if (!rst)
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (mode[i] == 0) ? (ptr[i] + k) % NP : k;
          if (eg < 0 && vld[i][p]) eg = p;
        end
      er = '0;
      ea = '0; ew = 1'b0; ed = '0;
      if (eg >= 0) begin
        er[eg] = 1'b1;
        ea = adr[i][eg*AW +: AW];
        ew = wr[i][eg];
        ed = wdt[i][eg*DW +: DW];
      end
      chk("req_ready", i, 128'(rdy[i]), 128'(er));
      chk("mem_drive", i, {maddr[i], mre[i], mwe[i], mwv[i]},
          {ea, (eg >= 0) && !ew, (eg >= 0) && ew, ed});
      if (eg >= 0) begin
        if (ew) begin
          rmem[i][ea] = ed;
        end else begin
          e.port = 8'(eg);
          e.data = rmem[i][ea];
          e.due  = cyc + lat[i] + 1;
          expq[i].push_back(e);
        end
      end
      gnt[i]     = eg;
      granted[i] = rdy[i] & vld[i];
    end
  end

  // Response monitor: pops the scoreboard whenever a DUT presents rsp_valid.
  initial forever begin
    @(negedge clk);
    if (cyc >= 1)
      for (int i = 0; i < 2; i++) begin
        logic [NP*DW-1:0] er;
        for (int p = 0; p < NP; p++)
          if (rsv[i][p]) begin
            if (expq[i].size() == 0) begin
              chk("unexpected_rsp", i, 128'(p), 128'hffff);
            end else begin
              rsp_t e;
              e = expq[i].pop_front();
              chk("rsp_port_data", i, {p[7:0], rdt[i][p*DW +: DW]}, {e.port, e.data});
              chk("rsp_cycle", i, 128'(cyc), 128'(e.due));
              exp_rd[i][e.port[1:0]] = e.data;
            end
          end
        while (expq[i].size() > 0 && expq[i][0].due < cyc) begin
          rsp_t e;
          e = expq[i].pop_front();
          chk("missing_rsp", i, 128'(cyc), 128'(e.due));
        end
        for (int p = 0; p < NP; p++) er[p*DW +: DW] = exp_rd[i][p];
        chk("rsp_rdata_hold", i, 128'(rdt[i]), 128'(er));
      end
  end

  task automatic new_req(input int i, input int p, input logic w);
    vld[i][p]            = 1'b1;
    wr[i][p]             = w;
    adr[i][p*AW +: AW]   = AW'($urandom_range(0, 15));
    wdt[i][p*DW +: DW]   = $urandom;
  endtask

  // phase 0 = idle, 1 = every port reading back-to-back, 2 = random mix with drops.
  task automatic drive(input int phase);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NP; p++) begin
        if (granted[i][p]) vld[i][p] = 1'b0;
        case (phase)
          0: vld[i][p] = 1'b0;
          1: if (!vld[i][p]) new_req(i, p, 1'b0);
          default: begin
            if (!vld[i][p]) begin
              if ($urandom_range(0, 1) == 1) new_req(i, p, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
              vld[i][p] = 1'b0;
            end
          end
        endcase
      end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = '0; wr[i] = '0; adr[i] = '0; wdt[i] = '0; granted[i] = '0;
      for (int p = 0; p < NP; p++) exp_rd[i][p] = '0;
      for (int k = 0; k < 4; k++) pipe[i][k] = '0;
      for (int a = 0; a < 256; a++) begin
        bmem[i][a] = $urandom;
        rmem[i][a] = bmem[i][a];
      end
    end
    repeat (3) drive(0);
    rst = 1'b0;
    repeat (20)  drive(1);
    repeat (5)   drive(0);
    repeat (400) drive(2);
    repeat (6)   drive(1);
    rst = 1'b1;
    drive(1);
    rst = 1'b0;
    repeat (10)  drive(1);
    repeat (400) drive(2);
    repeat (10)  drive(0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("drain_empty", i, 128'(expq[i].size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
